// File: rtl/aes128_out_serializer.sv
// aes128_out_serializer
// Streams a DATA_WIDTH ciphertext word out as OUT_WIDTH beats, LSB slice first,
// over a valid/ready handshake. One word of input buffering (hbuf) lets the
// next word be captured while the current one shifts out, so back-to-back
// words leave the block with no bubble. Also keeps a transferred-word counter
// and an XOR signature of every transferred beat.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | shift register empty, out_valid low
// SHIFT | sreg holds a word being streamed, out_valid high
module aes128_out_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [15:0]           words_sent,
  output logic [OUT_WIDTH-1:0]  signature
);

  localparam int BEATS = DATA_WIDTH / OUT_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  hbuf;
  logic                   hvalid;
  logic [DATA_WIDTH-1:0]  sreg;
  logic [CW-1:0]          cnt;
  logic [15:0]            words_q;
  logic [OUT_WIDTH-1:0]   sig_q;

  logic busy;
  logic accept;
  logic xfer;
  logic last_xfer;
  logic load;

  // Handshake decode; a load on the last beat transfer keeps the stream gapless.
  always_comb begin
    busy      = (state == SHIFT);
    accept    = in_valid && !hvalid;
    xfer      = busy && out_ready;
    last_xfer = xfer && (cnt == LAST_CNT);
    load      = hvalid && (!busy || last_xfer);
  end

  // Hold buffer, shift register, beat counter and the IDLE/SHIFT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hbuf   <= '0;
      hvalid <= 1'b0;
      sreg   <= '0;
      cnt    <= '0;
    end else begin
      // accept and load are mutually exclusive: accept needs !hvalid, load needs hvalid
      if (accept) begin
        hbuf   <= in_data;
        hvalid <= 1'b1;
      end
      if (load) begin
        sreg   <= hbuf;
        cnt    <= '0;
        hvalid <= 1'b0;
        state  <= SHIFT;
      end else if (xfer) begin
        sreg <= sreg >> OUT_WIDTH;
        if (last_xfer) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Word counter (free-running wrap) and XOR signature of transferred beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      words_q <= '0;
      sig_q   <= '0;
    end else begin
      if (xfer) begin
        sig_q <= sig_q ^ sreg[OUT_WIDTH-1:0];
      end
      if (last_xfer) begin
        words_q <= words_q + 16'd1;
      end
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    in_ready   = !hvalid;
    out_valid  = busy;
    out_data   = sreg[OUT_WIDTH-1:0];
    out_last   = busy && (cnt == LAST_CNT);
    words_sent = words_q;
    signature  = sig_q;
  end

endmodule

// File: tb/tb_aes128_out_serializer.sv
// Directed bench for aes128_out_serializer: latency, table of words (with and
// without backpressure), back-to-back streaming, reset mid-word and wrap.
module tb_aes128_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [15:0]  words_sent;
  logic [7:0]   signature;

  int total = 0;
  int bad   = 0;

  aes128_out_serializer #(.DATA_WIDTH(128), .OUT_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .words_sent (words_sent),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // out_ready driver: 1,0,0,1 pattern when backpressure is enabled
  bit         bp_mode = 1'b0;
  logic [0:3] bp_pat  = 4'b1001;
  int         bp_k    = 0;
  always @(negedge clk) begin
    if (bp_mode) begin
      out_ready = bp_pat[bp_k];
      bp_k = (bp_k + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Beat monitor plus stall-hold check
  logic [8:0] beats[$];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(posedge clk) begin
    if (prev_stall) begin
      chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
      chk("stall_data_hold", {24'd0, out_data}, {24'd0, prev_data});
    end
    if (rst_n && out_valid && out_ready) beats.push_back({out_last, out_data});
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_word(input logic [127:0] d);
    in_data  = d;
    in_valid = 1'b1;
    wait_accept();
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_beats(input logic [127:0] d, input int base);
    logic [7:0] exp_b;
    chk("beat_count_min", {31'd0, beats.size() >= base + 16}, 32'd1);
    if (beats.size() >= base + 16) begin
      for (int i = 0; i < 16; i++) begin
        exp_b = d[i*8 +: 8];
        chk($sformatf("beat%0d_data", i), {24'd0, beats[base+i][7:0]}, {24'd0, exp_b});
        chk($sformatf("beat%0d_last", i), {31'd0, beats[base+i][8]}, (i == 15) ? 32'd1 : 32'd0);
      end
    end
  endtask

  typedef struct {
    logic [127:0] data;
    bit           bp;
    logic [7:0]   sig;
    logic [15:0]  words;
  } vec_t;

  vec_t vecs[3];

  initial begin
    vecs[0] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 8'h00, 16'd2};
    vecs[1] = '{128'h0000000000000000000000000000005a, 1'b0, 8'h5a, 16'd3};
    vecs[2] = '{128'hff0000000000000000000000000000a5, 1'b0, 8'h00, 16'd4};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_words", {16'd0, words_sent}, 32'd0);
    chk("rst_sig", {24'd0, signature}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // single word with latency check
    beats.delete();
    in_data  = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("lat_out_valid_low", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_out_valid_high", {31'd0, out_valid}, 32'd1);
    chk("lat_first_beat", {24'd0, out_data}, 32'hff);
    chk("lat_in_ready_back", {31'd0, in_ready}, 32'd1);
    wait_idle();
    check_beats(128'h00112233445566778899aabbccddeeff, 0);
    chk("single_words", {16'd0, words_sent}, 32'd1);
    chk("single_sig", {24'd0, signature}, 32'h00);

    // table of words
    for (int v = 0; v < 3; v++) begin
      beats.delete();
      bp_mode = vecs[v].bp;
      run_word(vecs[v].data);
      bp_mode = 1'b0;
      chk($sformatf("vec%0d_nbeats", v), beats.size(), 32'd16);
      check_beats(vecs[v].data, 0);
      chk($sformatf("vec%0d_words", v), {16'd0, words_sent}, {16'd0, vecs[v].words});
      chk($sformatf("vec%0d_sig", v), {24'd0, signature}, {24'd0, vecs[v].sig});
      @(negedge clk);
    end

    // back-to-back, in_valid held high across two accepts
    beats.delete();
    fork
      begin
        in_data  = 128'h1;
        in_valid = 1'b1;
        wait_accept();
        in_data = 128'h2;
        wait_accept();
        in_valid = 1'b0;
      end
      begin
        int run = 0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        while (out_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
        chk("b2b_run_length", run, 32'd32);
      end
    join
    wait_idle();
    chk("b2b_nbeats", beats.size(), 32'd32);
    check_beats(128'h1, 0);
    check_beats(128'h2, 16);
    chk("b2b_words", {16'd0, words_sent}, 32'd6);
    chk("b2b_sig", {24'd0, signature}, 32'h03);

    // reset mid-word with a second word buffered
    @(negedge clk);
    beats.delete();
    in_data  = 128'h0f0e0d0c0b0a09080706050403020100;
    in_valid = 1'b1;
    wait_accept();
    in_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    for (int i = 0; i < 40 && beats.size() < 5; i++) @(negedge clk);
    chk("mid_beats_before_rst", beats.size(), 32'd5);
    chk("mid_hbuf_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_out_last", {31'd0, out_last}, 32'd0);
    chk("mid_out_data", {24'd0, out_data}, 32'd0);
    chk("mid_words", {16'd0, words_sent}, 32'd0);
    chk("mid_sig", {24'd0, signature}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    beats.delete();
    run_word(128'h5a);
    chk("post_rst_nbeats", beats.size(), 32'd16);
    check_beats(128'h5a, 0);
    chk("post_rst_words", {16'd0, words_sent}, 32'd1);
    chk("post_rst_sig", {24'd0, signature}, 32'h5a);

    // counter wrap: preset the count near the top, then stream zero words
    @(negedge clk);
    force dut.words_q = 16'hfffe;
    @(negedge clk);
    release dut.words_q;
    @(negedge clk);
    run_word(128'h0);
    chk("wrap_ffff", {16'd0, words_sent}, 32'h0000ffff);
    run_word(128'h0);
    chk("wrap_zero", {16'd0, words_sent}, 32'h00000000);
    chk("wrap_sig", {24'd0, signature}, 32'h5a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
